// File: rtl/rgb_mixer.sv
// rgb_mixer: mixes an RGB colour from three rotary encoders into three PWM outputs plus a period sync pulse
// Ports: clk; reset (sync, active-high); encN_a/encN_b asynchronous quadrature inputs (0 red, 1 green, 2 blue);
//        pwmN_out registered PWM per channel; sync registered one-cycle pulse at PWM counter 0.
// Define RGB_MIXER_SATURATE_EN to clamp levels at 0/255 instead of wrapping modulo 256.
module rgb_mixer #(
  parameter int DEBOUNCE_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enc0_a,
  input  logic enc0_b,
  input  logic enc1_a,
  input  logic enc1_b,
  input  logic enc2_a,
  input  logic enc2_b,
  output logic pwm0_out,
  output logic pwm1_out,
  output logic pwm2_out,
  output logic sync
);
  logic [5:0] raw, s1_q, s2_q, deb_q, deb_d, old_q;
  logic [DEBOUNCE_LEN-1:0] sh_q [6];
  logic [7:0] lvl_q [3];
  logic [7:0] lvl_d [3];
  logic [7:0] cnt_q;
  logic [2:0] pwm_q;
  logic sync_q;
  assign raw = {enc2_b, enc2_a, enc1_b, enc1_a, enc0_b, enc0_a};
  for (genvar i = 0; i < 6; i++) begin : g_deb
    assign deb_d[i] = &sh_q[i] ? 1'b1 : (~|sh_q[i] ? 1'b0 : deb_q[i]);
  end
  for (genvar i = 0; i < 3; i++) begin : g_lvl
    logic a, b, oa, ob, step, up, dn;
    assign a = deb_q[2*i];
    assign b = deb_q[2*i+1];
    assign oa = old_q[2*i];
    assign ob = old_q[2*i+1];
    // exactly one bit of the pair changed; direction follows old_a vs new_b
    assign step = a ^ oa ^ b ^ ob;
    assign up = step & ~(oa ^ b);
    assign dn = step & (oa ^ b);
`ifdef RGB_MIXER_SATURATE_EN
    assign lvl_d[i] = (up && lvl_q[i] != 8'hff) ? lvl_q[i] + 8'd1 :
                      (dn && lvl_q[i] != 8'h00) ? lvl_q[i] - 8'd1 : lvl_q[i];
`else
    assign lvl_d[i] = up ? lvl_q[i] + 8'd1 : (dn ? lvl_q[i] - 8'd1 : lvl_q[i]);
`endif
  end
  always_ff @(posedge clk)
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      deb_q <= '0;
      old_q <= '0;
      cnt_q <= '0;
      pwm_q <= '0;
      sync_q <= 1'b0;
      for (int n = 0; n < 6; n++) sh_q[n] <= '0;
      for (int n = 0; n < 3; n++) lvl_q[n] <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      deb_q <= deb_d;
      old_q <= deb_q;
      cnt_q <= cnt_q + 8'd1;
      sync_q <= cnt_q == 8'd0;
      for (int n = 0; n < 6; n++) sh_q[n] <= {sh_q[n][DEBOUNCE_LEN-2:0], s2_q[n]};
      for (int n = 0; n < 3; n++) begin
        lvl_q[n] <= lvl_d[n];
        pwm_q[n] <= cnt_q < lvl_q[n];
      end
    end
  assign pwm0_out = pwm_q[0];
  assign pwm1_out = pwm_q[1];
  assign pwm2_out = pwm_q[2];
  assign sync = sync_q;
endmodule

// File: tb/tb_rgb_mixer.sv
// tb_rgb_mixer: drives encoder steps and glitches, compares measured PWM duties against an encoder position/level model
module tb_rgb_mixer;
  localparam int L = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic e0a = 1'b0, e0b = 1'b0, e1a = 1'b0, e1b = 1'b0, e2a = 1'b0, e2b = 1'b0;
  logic p0, p1, p2, sy;
  int checks = 0;
  int passes = 0;
  int lvl [3] = '{0, 0, 0};
  int pos [3] = '{0, 0, 0};
  int duty [3];
  int at_sync [3];
  int tgt [3];
  int syncs, wide, prev;
  int hi [3];
  int idx [$];
  always #5 clk = ~clk;
  rgb_mixer #(.DEBOUNCE_LEN(L)) dut (
    .clk(clk), .reset(reset),
    .enc0_a(e0a), .enc0_b(e0b), .enc1_a(e1a), .enc1_b(e1b), .enc2_a(e2a), .enc2_b(e2b),
    .pwm0_out(p0), .pwm1_out(p1), .pwm2_out(p2), .sync(sy)
  );
  function automatic int step_lvl(int lv, int d);
`ifdef RGB_MIXER_SATURATE_EN
    return (lv + d > 255) ? 255 : ((lv + d < 0) ? 0 : lv + d);
`else
    return (lv + d + 256) % 256;
`endif
  endfunction
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic drive();
    int ph [3];
    for (int c = 0; c < 3; c++) ph[c] = ((pos[c] % 4) + 4) % 4;
    e0a = (ph[0] == 1 || ph[0] == 2);
    e0b = (ph[0] >= 2);
    e1a = (ph[1] == 1 || ph[1] == 2);
    e1b = (ph[1] >= 2);
    e2a = (ph[2] == 1 || ph[2] == 2);
    e2b = (ph[2] >= 2);
  endtask
  task automatic move(input int d0, input int d1, input int d2);
    int rem [3];
    rem = '{d0, d1, d2};
    while (rem[0] != 0 || rem[1] != 0 || rem[2] != 0) begin
      for (int c = 0; c < 3; c++)
        if (rem[c] != 0) begin
          int s;
          s = rem[c] > 0 ? 1 : -1;
          pos[c] += s;
          lvl[c] = step_lvl(lvl[c], s);
          rem[c] -= s;
        end
      drive();
      repeat (2 * L) @(negedge clk);
    end
    repeat (20) @(negedge clk);
  endtask
  task automatic wait_sync();
    int n;
    n = 0;
    while (sy !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("sync_seen", int'(sy), 1);
  endtask
  task automatic measure();
    duty = '{0, 0, 0};
    wait_sync();
    at_sync = '{int'(p0), int'(p1), int'(p2)};
    for (int i = 0; i < 256; i++) begin
      duty[0] += int'(p0);
      duty[1] += int'(p1);
      duty[2] += int'(p2);
      @(negedge clk);
    end
  endtask
  task automatic check_duties(input string tag);
    for (int c = 0; c < 3; c++) chk($sformatf("%s_duty%0d", tag, c), duty[c], lvl[c]);
  endtask
  initial begin
    drive();
    repeat (3) @(negedge clk);
    chk("rst_pwm0", int'(p0), 0);
    chk("rst_pwm1", int'(p1), 0);
    chk("rst_pwm2", int'(p2), 0);
    chk("rst_sync", int'(sy), 0);
    reset = 1'b0;
    syncs = 0;
    wide = 0;
    prev = 0;
    hi = '{0, 0, 0};
    for (int i = 0; i < 1024; i++) begin
      if (sy === 1'b1) begin
        syncs++;
        idx.push_back(i);
        if (prev == 1) wide++;
      end
      prev = int'(sy);
      hi[0] += int'(p0);
      hi[1] += int'(p1);
      hi[2] += int'(p2);
      @(negedge clk);
    end
    chk("idle_sync_count", syncs, 4);
    for (int k = 1; k < idx.size(); k++) chk($sformatf("idle_sync_gap%0d", k), idx[k] - idx[k-1], 256);
    chk("idle_sync_wide", wide, 0);
    for (int c = 0; c < 3; c++) chk($sformatf("idle_pwm%0d_high", c), hi[c], 0);
    move(16, 0, 0);
    measure();
    check_duties("fwd16");
    move(0, 8, 0);
    move(0, -3, 0);
    measure();
    check_duties("fwd8rev3");
    chk("lvl1_model", lvl[1], 5);
    chk("pwm1_at_sync", at_sync[1], 1);
    e2a = 1'b1;
    repeat (3) @(negedge clk);
    e2a = 1'b0;
    repeat (30) @(negedge clk);
    measure();
    check_duties("glitch");
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) tgt[c] = int'($urandom_range(0, 255));
      move(tgt[0] - lvl[0], tgt[1] - lvl[1], tgt[2] - lvl[2]);
      measure();
      check_duties($sformatf("rand%0d", r));
    end
    move(100 - lvl[0], 100 - lvl[1], 100 - lvl[2]);
    measure();
    check_duties("lvl100");
    wait_sync();
    chk("pre_reset_pwm0", int'(p0), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_pwm0", int'(p0), 0);
    chk("mid_rst_pwm1", int'(p1), 0);
    chk("mid_rst_pwm2", int'(p2), 0);
    chk("mid_rst_sync", int'(sy), 0);
    reset = 1'b0;
    lvl = '{0, 0, 0};
    repeat (20) @(negedge clk);
    measure();
    check_duties("after_rst");
    move(-1, 0, 0);
    measure();
    check_duties("rev_from0");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
